// File: rtl/cardinal_nic_pkg.sv
// Shared definitions for the cardinal NIC: register map, packet field positions
// (common with the XY mesh router) and the virtual-channel gating helper.
package cardinal_nic_pkg;

  typedef enum logic [1:0] {
    NIC_ADDR_IBUF  = 2'd0,
    NIC_ADDR_ISTAT = 2'd1,
    NIC_ADDR_OBUF  = 2'd2,
    NIC_ADDR_OSTAT = 2'd3
  } nic_addr_e;

  localparam int PKT_VC_BIT  = 63;
  localparam int PKT_DX_MSB  = 55;
  localparam int PKT_DX_LSB  = 48;
  localparam int PKT_DY_MSB  = 47;
  localparam int PKT_DY_LSB  = 40;
  localparam int PKT_HOP_MSB = 39;
  localparam int PKT_HOP_LSB = 32;

  // A packet may enter the router only in the phase matching its virtual channel.
  function automatic logic vc_phase_match(input logic vc, input logic polarity);
    return (vc == polarity);
  endfunction

endpackage

// File: rtl/cardinal_nic_chan_buf.sv
// One-deep channel buffer: data register plus full flag. A load is taken only
// while empty; a clear only drops the flag, so the data stays readable.
module cardinal_nic_chan_buf #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              full
);

  logic [DATA_W-1:0] data_r;
  logic              full_r;

  // Buffer storage and occupancy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r <= {DATA_W{1'b0}};
      full_r <= 1'b0;
    end else if (full_r) begin
      if (clear) begin
        full_r <= 1'b0;
      end else begin
        full_r <= 1'b1;
      end
    end else if (load) begin
      data_r <= d;
      full_r <= 1'b1;
    end else begin
      full_r <= 1'b0;
    end
  end

  assign q    = data_r;
  assign full = full_r;

endmodule

// File: rtl/cardinal_nic.sv
// Processor-to-router network interface: 4-word register map, one-packet output
// channel gated by router readiness and VC phase, one-packet input channel.
module cardinal_nic
  import cardinal_nic_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 2,
  parameter int VC_BIT = PKT_VC_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_so,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_ri,
  input  logic              net_si,
  input  logic [DATA_W-1:0] net_di,
  output logic              net_ro,
  input  logic              net_polarity
);

  nic_addr_e         addr_s;
  logic              rd_en_s;
  logic              wr_en_s;
  logic [DATA_W-1:0] ibuf_data_s;
  logic              ibuf_full_s;
  logic [DATA_W-1:0] obuf_data_s;
  logic              obuf_full_s;
  logic              ibuf_load_s;
  logic              ibuf_clear_s;
  logic              obuf_load_s;
  logic              send_s;

  assign addr_s  = nic_addr_e'(addr[1:0]);
  assign rd_en_s = nicEn & ~nicWrEn;
  assign wr_en_s = nicEn & nicWrEn;

  // Reading the input buffer while full consumes the packet.
  assign ibuf_clear_s = rd_en_s & (addr_s == NIC_ADDR_IBUF);
  assign ibuf_load_s  = net_si & net_ro;
  assign obuf_load_s  = wr_en_s & (addr_s == NIC_ADDR_OBUF);

  assign send_s = obuf_full_s & net_ri & vc_phase_match(obuf_data_s[VC_BIT], net_polarity);

  cardinal_nic_chan_buf #(.DATA_W(DATA_W)) u_ibuf (
    .clk   (clk),
    .reset (reset),
    .load  (ibuf_load_s),
    .clear (ibuf_clear_s),
    .d     (net_di),
    .q     (ibuf_data_s),
    .full  (ibuf_full_s)
  );

  cardinal_nic_chan_buf #(.DATA_W(DATA_W)) u_obuf (
    .clk   (clk),
    .reset (reset),
    .load  (obuf_load_s),
    .clear (send_s),
    .d     (d_in),
    .q     (obuf_data_s),
    .full  (obuf_full_s)
  );

  assign net_so = send_s;
  assign net_do = obuf_data_s;
  assign net_ro = ~ibuf_full_s;

  // Processor read-data mux
  always_comb begin
    d_out = {DATA_W{1'b0}};
    if (rd_en_s) begin
      case (addr_s)
        NIC_ADDR_IBUF:  d_out = ibuf_data_s;
        NIC_ADDR_ISTAT: d_out = {{(DATA_W-1){1'b0}}, ibuf_full_s};
        NIC_ADDR_OBUF:  d_out = obuf_data_s;
        NIC_ADDR_OSTAT: d_out = {{(DATA_W-1){1'b0}}, obuf_full_s};
        default:        d_out = {DATA_W{1'b0}};
      endcase
    end else begin
      d_out = {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// Self-checking bench for cardinal_nic: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_cardinal_nic;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_so;
  logic [63:0] net_do;
  logic        net_ri;
  logic        net_si;
  logic [63:0] net_di;
  logic        net_ro;
  logic        net_polarity;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the NIC's architectural state
  logic [63:0] m_ibuf;
  logic        m_ibuf_full;
  logic [63:0] m_obuf;
  logic        m_obuf_full;

  cardinal_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_so       (net_so),
    .net_do       (net_do),
    .net_ri       (net_ri),
    .net_si       (net_si),
    .net_di       (net_di),
    .net_ro       (net_ro),
    .net_polarity (net_polarity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_send();
    return m_obuf_full && net_ri && (m_obuf[63] == net_polarity);
  endfunction

  // Compare every DUT output with what the model says for the current inputs.
  task automatic compare_model();
    logic [63:0] exp_dout;
    exp_dout = 64'd0;
    if (nicEn && !nicWrEn) begin
      case (addr)
        2'd0: exp_dout = m_ibuf;
        2'd1: exp_dout = {63'd0, m_ibuf_full};
        2'd2: exp_dout = m_obuf;
        default: exp_dout = {63'd0, m_obuf_full};
      endcase
    end
    check("model_net_so", {63'd0, net_so}, {63'd0, model_send()});
    check("model_net_do", net_do, m_obuf);
    check("model_net_ro", {63'd0, net_ro}, {63'd0, ~m_ibuf_full});
    check("model_d_out", d_out, exp_dout);
  endtask

  task automatic update_model();
    logic send;
    send = model_send();
    if (reset) begin
      m_ibuf = 64'd0; m_ibuf_full = 1'b0;
      m_obuf = 64'd0; m_obuf_full = 1'b0;
    end else begin
      if (nicEn && !nicWrEn && addr == 2'd0 && m_ibuf_full) m_ibuf_full = 1'b0;
      else if (net_si && !m_ibuf_full) begin
        m_ibuf = net_di; m_ibuf_full = 1'b1;
      end
      if (send) m_obuf_full = 1'b0;
      else if (nicEn && nicWrEn && addr == 2'd2 && !m_obuf_full) begin
        m_obuf = d_in; m_obuf_full = 1'b1;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    compare_model();
  endtask

  task automatic advance();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; addr = 2'd0; d_in = 64'd0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_ri = 1'b0; net_si = 1'b0; net_di = 64'd0; net_polarity = 1'b0;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic set_rd(input logic [1:0] a);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
  endtask

  task automatic set_wr(input logic [1:0] a, input logic [63:0] d);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = d;
  endtask

  initial begin
    int pulses;
    idle();
    m_ibuf = 64'd0; m_ibuf_full = 1'b0; m_obuf = 64'd0; m_obuf_full = 1'b0;
    @(posedge clk); #1;

    // 1 reset
    reset = 1'b1; advance(); advance();
    reset = 1'b0;
    set_rd(2'd1); sample();
    check("rst_net_so", {63'd0, net_so}, 64'd0);
    check("rst_net_ro", {63'd0, net_ro}, 64'd1);
    check("rst_istat", d_out, 64'd0);
    check("rst_net_do", net_do, 64'd0);
    advance();
    set_rd(2'd3); sample();
    check("rst_ostat", d_out, 64'd0);
    advance();

    // 2 inject, gated by polarity
    idle(); net_ri = 1'b1;
    set_wr(2'd2, 64'h8000_0000_0000_00A5); cyc();
    idle(); net_ri = 1'b1; net_polarity = 1'b0; sample();
    check("inj_wrong_phase_so", {63'd0, net_so}, 64'd0);
    advance();
    net_polarity = 1'b1; sample();
    check("inj_phase_so", {63'd0, net_so}, 64'd1);
    check("inj_net_do", net_do, 64'h8000_0000_0000_00A5);
    advance();
    idle(); set_rd(2'd3); sample();
    check("inj_ostat_clear", d_out, 64'd0);
    advance();

    // 3 backpressure
    idle(); set_wr(2'd2, 64'h8000_0000_0000_00A5); cyc();
    idle(); net_polarity = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) set_wr(2'd2, 64'h1234);
      else idle();
      net_polarity = 1'b1;
      sample();
      if (net_so) pulses++;
      advance();
    end
    check("bp_no_send", pulses, 0);
    idle(); set_rd(2'd2); sample();
    check("bp_obuf_kept", d_out, 64'h8000_0000_0000_00A5);
    advance();
    idle(); net_ri = 1'b1; net_polarity = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      sample();
      if (net_so) pulses++;
      advance();
    end
    check("bp_single_pulse", pulses, 1);

    // back-to-back: write in same cycle as send is dropped
    idle(); set_wr(2'd2, 64'h8000_0000_0000_0001); cyc();
    idle(); net_ri = 1'b1; net_polarity = 1'b1; set_wr(2'd2, 64'h0000_0000_0000_0002);
    sample();
    check("b2b_send", {63'd0, net_so}, 64'd1);
    advance();
    idle(); set_rd(2'd3); sample();
    check("b2b_dropped", d_out, 64'd0);
    advance();

    // 4 eject
    idle(); net_si = 1'b1; net_di = 64'hDEAD_BEEF; cyc();
    idle(); set_rd(2'd1); sample();
    check("ej_net_ro", {63'd0, net_ro}, 64'd0);
    check("ej_istat", d_out, 64'd1);
    advance();
    idle(); set_rd(2'd0); sample();
    check("ej_read", d_out, 64'hDEAD_BEEF);
    advance();
    idle(); set_rd(2'd1); sample();
    check("ej_ro_back", {63'd0, net_ro}, 64'd1);
    check("ej_istat_clear", d_out, 64'd0);
    advance();
    idle(); set_rd(2'd0); sample();
    check("ej_stale_read", d_out, 64'hDEAD_BEEF);
    advance();

    // 5 overrun
    idle(); net_si = 1'b1; net_di = 64'hDEAD_BEEF; cyc();
    idle(); net_si = 1'b1; net_di = 64'h5555; cyc();
    idle(); set_rd(2'd0); sample();
    check("ovr_keep", d_out, 64'hDEAD_BEEF);
    advance();
    idle(); net_si = 1'b1; net_di = 64'hDEAD_BEEF; cyc();

    // 6 reset mid-operation
    idle(); set_wr(2'd2, 64'h0000_0000_0000_0077); cyc();
    idle(); reset = 1'b1; net_si = 1'b1; net_di = 64'h9999; cyc();
    idle(); set_rd(2'd1); sample();
    check("rmid_istat", d_out, 64'd0);
    check("rmid_net_ro", {63'd0, net_ro}, 64'd1);
    check("rmid_net_so", {63'd0, net_so}, 64'd0);
    advance();
    idle(); set_rd(2'd3); sample();
    check("rmid_ostat", d_out, 64'd0);
    advance();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 99) == 0);
      addr         = 2'($urandom_range(0, 3));
      nicEn        = 1'($urandom_range(0, 1));
      nicWrEn      = 1'($urandom_range(0, 1));
      d_in         = {32'($urandom), 32'($urandom)};
      net_ri       = ($urandom_range(0, 3) != 0);
      net_polarity = 1'($urandom_range(0, 1));
      net_si       = 1'($urandom_range(0, 1));
      net_di       = {32'($urandom), 32'($urandom)};
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
